// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Stage-control words bundle every enable/flush so priority arms assign one value.
package pipeline_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_BUSY  = 2'd1,
    MC_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
    logic mc_start;
  } ctrl_t;

  // Flushes are paired with a set write-enable so the bubble is actually loaded.
  localparam ctrl_t CTRL_NORMAL   = 10'b11111_0000_0;
  localparam ctrl_t CTRL_RESET    = 10'b00000_1111_0;
  localparam ctrl_t CTRL_MEM_WAIT = 10'b00001_0001_0;
  localparam ctrl_t CTRL_MC_START = 10'b00011_0010_1;
  localparam ctrl_t CTRL_MC_HOLD  = 10'b00011_0010_0;
  localparam ctrl_t CTRL_REDIRECT = 10'b11111_1100_0;
  localparam ctrl_t CTRL_LOAD_USE = 10'b00111_0100_0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/flushes, multi-cycle EX handshake, watchdog and perf counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal issue; load-use, redirect and mc start resolved here
// MC_BUSY  | multi-cycle op in flight, front end frozen, waiting mc_done
// MC_DRAIN | mc_done seen under a dmem wait; release once the wait ends
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_AW = pipeline_ctrl_pkg::REG_AW,
  parameter int CNT_W  = 16,
  parameter int MC_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic              ex_branch_taken,
  input  logic              ex_mc_op,
  input  logic              mc_done,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              id_ex_we,
  output logic              ex_mem_we,
  output logic              mem_wb_we,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic              mc_start,
  output logic              mc_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  redirect_cnt
);

  localparam int WD_W = $clog2(MC_MAX + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MC_MAX);
  localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

  state_e          state;
  logic            done_pend;
  logic [WD_W-1:0] wdog;
  logic [WD_W-1:0] wdog_nxt;
  logic            mem_wait;
  logic            load_use;
  logic            mc_release;
  logic            redirect;
  ctrl_t           ctrl;

  assign mem_wait = mem_req & ~mem_ready;

  assign load_use = ex_mem_read & ex_reg_write & (ex_rd != '0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  // The result advances on the done cycle itself, or on the first wait-free cycle after a drain.
  assign mc_release = ((state == MC_BUSY) & mc_done) |
                      ((state == MC_DRAIN) & done_pend);

  assign wdog_nxt = (wdog == WD_MAX) ? wdog : wdog + WD_ONE;

  always_comb begin
    ctrl     = CTRL_NORMAL;
    redirect = 1'b0;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else if (mem_wait) begin
      ctrl = CTRL_MEM_WAIT;
    end else if (state != RUN) begin
      ctrl = mc_release ? CTRL_NORMAL : CTRL_MC_HOLD;
    end else if (ex_mc_op) begin
      ctrl = CTRL_MC_START;
    end else if (ex_branch_taken) begin
      ctrl     = CTRL_REDIRECT;
      redirect = 1'b1;
    end else if (load_use) begin
      ctrl = CTRL_LOAD_USE;
    end
  end

  assign {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mc_start} = ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      done_pend  <= 1'b0;
      wdog       <= '0;
      mc_timeout <= 1'b0;
    end else begin
      if (state != RUN) begin
        wdog <= wdog_nxt;
        if (wdog_nxt >= WD_MAX) begin
          mc_timeout <= 1'b1;
        end
      end
      case (state)
        RUN: begin
          if (!mem_wait && ex_mc_op) begin
            state <= MC_BUSY;
            wdog  <= WD_ONE;
          end
        end
        MC_BUSY: begin
          if (mc_done) begin
            if (mem_wait) begin
              done_pend <= 1'b1;
              state     <= MC_DRAIN;
            end else begin
              state <= RUN;
            end
          end
        end
        MC_DRAIN: begin
          if (!mem_wait) begin
            done_pend <= 1'b0;
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~rst & ~pc_we),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect),
    .q   (redirect_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a wide-counter instance plus a small
// instance (CNT_W=3, MC_MAX=8) sharing stimulus for saturation and watchdog cases.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam logic [9:0] E_NORMAL   = 10'b11111_0000_0;
  localparam logic [9:0] E_RESET    = 10'b00000_1111_0;
  localparam logic [9:0] E_MEMWAIT  = 10'b00001_0001_0;
  localparam logic [9:0] E_MCSTART  = 10'b00011_0010_1;
  localparam logic [9:0] E_MCHOLD   = 10'b00011_0010_0;
  localparam logic [9:0] E_BRANCH   = 10'b11111_1100_0;
  localparam logic [9:0] E_LOADUSE  = 10'b00111_0100_0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [REG_AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_reg_write = 0;
  logic ex_branch_taken = 0, ex_mc_op = 0, mc_done = 0, mem_req = 0, mem_ready = 0;

  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mc_start, mc_timeout;
  logic [15:0] stall_cycles, redirect_cnt;
  logic s_pc_we, s_if_id_we, s_id_ex_we, s_ex_mem_we, s_mem_wb_we;
  logic s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush, s_mc_start, s_mc_timeout;
  logic [2:0] s_stall_cycles, s_redirect_cnt;

  int n_chk = 0;
  int n_fail = 0;
  logic [9:0] last_ov;

  typedef struct {
    string      nm;
    logic [9:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string           nm;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic            u1, u2, mr, rw, br, req, rdy;
    logic [9:0]      exp;
    logic            redir;
  } vec_t;
  vec_t tbl[14];

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_mc_op(ex_mc_op), .mc_done(mc_done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .mc_start(mc_start),
    .mc_timeout(mc_timeout), .stall_cycles(stall_cycles), .redirect_cnt(redirect_cnt)
  );

  pipeline_ctrl #(.CNT_W(3), .MC_MAX(8)) dut_s (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_mc_op(ex_mc_op), .mc_done(mc_done),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(s_pc_we), .if_id_we(s_if_id_we), .id_ex_we(s_id_ex_we), .ex_mem_we(s_ex_mem_we),
    .mem_wb_we(s_mem_wb_we), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
    .ex_mem_flush(s_ex_mem_flush), .mem_wb_flush(s_mem_wb_flush), .mc_start(s_mc_start),
    .mc_timeout(s_mc_timeout), .stall_cycles(s_stall_cycles), .redirect_cnt(s_redirect_cnt)
  );

  wire [9:0] ov   = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                     if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mc_start};
  wire [9:0] ov_s = {s_pc_we, s_if_id_we, s_id_ex_we, s_ex_mem_we, s_mem_wb_we,
                     s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush, s_mc_start};

  always @(negedge clk) begin
    if (!rst) begin
      assert (!(ex_branch_taken && ex_mc_op))
        else $error("illegal stimulus: ex_branch_taken with ex_mc_op");
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_reg_write = 0;
    ex_branch_taken = 0; ex_mc_op = 0; mc_done = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Push the expectation for this cycle, sample mid-cycle, then advance past the edge.
  task automatic expect_cycle(input string nm, input logic [9:0] exp);
    sb_t e;
    sb_q.push_back('{nm: nm, exp: exp});
    @(negedge clk);
    e = sb_q.pop_front();
    last_ov = ov;
    check({e.nm, " outs"}, 32'(ov), 32'(e.exp));
    check({e.nm, " outs_s"}, 32'(ov_s), 32'(e.exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    expect_cycle("reset", E_RESET);
    rst = 1'b0;
    check("rst stall_cycles", 32'(stall_cycles), 32'd0);
    check("rst redirect_cnt", 32'(redirect_cnt), 32'd0);
    check("rst mc_timeout_s", 32'(s_mc_timeout), 32'd0);
  endtask

  function automatic vec_t mk(input string nm, input int rs1, input int rs2,
                              input logic u1, input logic u2, input int rd,
                              input logic mr, input logic rw, input logic br,
                              input logic req, input logic rdy,
                              input logic [9:0] exp, input logic redir);
    vec_t v;
    v.nm = nm; v.rs1 = REG_AW'(rs1); v.rs2 = REG_AW'(rs2); v.rd = REG_AW'(rd);
    v.u1 = u1; v.u2 = u2; v.mr = mr; v.rw = rw; v.br = br; v.req = req; v.rdy = rdy;
    v.exp = exp; v.redir = redir;
    return v;
  endfunction

  initial begin
    int exp_stall;
    int exp_redir;
    int n_exm;
    int n_mwbf;

    tbl[0]  = mk("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORMAL,  0);
    tbl[1]  = mk("lu_rs1",      5, 1, 1, 1, 5, 1, 1, 0, 0, 0, E_LOADUSE, 0);
    tbl[2]  = mk("lu_rs2",      3, 7, 1, 1, 7, 1, 1, 0, 0, 0, E_LOADUSE, 0);
    tbl[3]  = mk("rs1_unused",  5, 0, 0, 1, 5, 1, 1, 0, 0, 0, E_NORMAL,  0);
    tbl[4]  = mk("rd_x0",       0, 0, 1, 1, 0, 1, 1, 0, 0, 0, E_NORMAL,  0);
    tbl[5]  = mk("no_regwrite", 5, 5, 1, 1, 5, 1, 0, 0, 0, 0, E_NORMAL,  0);
    tbl[6]  = mk("not_load",    5, 5, 1, 1, 5, 0, 1, 0, 0, 0, E_NORMAL,  0);
    tbl[7]  = mk("no_match",    4, 6, 1, 1, 5, 1, 1, 0, 0, 0, E_NORMAL,  0);
    tbl[8]  = mk("br_over_lu",  5, 5, 1, 1, 5, 1, 1, 1, 0, 0, E_BRANCH,  1);
    tbl[9]  = mk("mw_over_lu",  5, 5, 1, 1, 5, 1, 1, 0, 1, 0, E_MEMWAIT, 0);
    tbl[10] = mk("mw_over_br",  0, 0, 0, 0, 0, 0, 0, 1, 1, 0, E_MEMWAIT, 0);
    tbl[11] = mk("mem_ready",   5, 5, 1, 1, 5, 1, 1, 0, 1, 1, E_LOADUSE, 0);
    tbl[12] = mk("branch",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_BRANCH,  1);
    tbl[13] = mk("rs2_unused",  2, 5, 1, 0, 5, 1, 1, 0, 0, 0, E_NORMAL,  0);

    @(posedge clk); #1;
    do_reset();

    // Single load-use bubble, then the load has moved on.
    id_rs1 = 5; id_rs2 = 5; id_uses_rs1 = 1; id_uses_rs2 = 1;
    ex_rd = 5; ex_mem_read = 1; ex_reg_write = 1;
    expect_cycle("lw_add", E_LOADUSE);
    ex_rd = 0; ex_mem_read = 0; ex_reg_write = 0;
    expect_cycle("lw_add_next", E_NORMAL);
    check("lw_add stall_cycles", 32'(stall_cycles), 32'd1);

    do_reset();
    exp_stall = 0;
    exp_redir = 0;
    for (int i = 0; i < 14; i++) begin
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; ex_rd = tbl[i].rd;
      id_uses_rs1 = tbl[i].u1; id_uses_rs2 = tbl[i].u2;
      ex_mem_read = tbl[i].mr; ex_reg_write = tbl[i].rw;
      ex_branch_taken = tbl[i].br; mem_req = tbl[i].req; mem_ready = tbl[i].rdy;
      ex_mc_op = 0; mc_done = 0;
      expect_cycle(tbl[i].nm, tbl[i].exp);
      if (!tbl[i].exp[9]) exp_stall++;
      if (tbl[i].redir) exp_redir++;
    end
    check("tbl stall_cycles", 32'(stall_cycles), 32'(exp_stall));
    check("tbl redirect_cnt", 32'(redirect_cnt), 32'(exp_redir));

    // Multi-cycle op with mc_done four cycles after the start.
    do_reset();
    ex_mc_op = 1;
    expect_cycle("mc start", E_MCSTART);
    for (int i = 1; i < 4; i++) expect_cycle("mc hold", E_MCHOLD);
    mc_done = 1;
    expect_cycle("mc done", E_NORMAL);
    mc_done = 0; ex_mc_op = 0;
    expect_cycle("mc after", E_NORMAL);
    check("mc stall_cycles", 32'(stall_cycles), 32'd4);

    // Deferred start, then mc_done landing inside a two-cycle dmem wait.
    do_reset();
    ex_mc_op = 1; mem_req = 1; mem_ready = 0;
    expect_cycle("defer start", E_MEMWAIT);
    mem_req = 0;
    expect_cycle("drain start", E_MCSTART);
    expect_cycle("drain hold", E_MCHOLD);
    n_exm = 0; n_mwbf = 0;
    mem_req = 1; mem_ready = 0; mc_done = 1;
    expect_cycle("drain wait1", E_MEMWAIT);
    n_exm += int'(last_ov[6]); n_mwbf += int'(last_ov[1]);
    mc_done = 0;
    expect_cycle("drain wait2", E_MEMWAIT);
    n_exm += int'(last_ov[6]); n_mwbf += int'(last_ov[1]);
    mem_ready = 1;
    expect_cycle("drain release", E_NORMAL);
    n_exm += int'(last_ov[6]); n_mwbf += int'(last_ov[1]);
    idle_inputs();
    expect_cycle("drain after", E_NORMAL);
    check("drain ex_mem_we count", 32'(n_exm), 32'd1);
    check("drain mem_wb_flush count", 32'(n_mwbf), 32'd2);
    check("drain stall_cycles", 32'(stall_cycles), 32'd5);

    // Watchdog on the MC_MAX=8 instance with no mc_done.
    do_reset();
    ex_mc_op = 1;
    expect_cycle("wd start", E_MCSTART);
    for (int i = 2; i <= 10; i++) begin
      expect_cycle("wd hold", E_MCHOLD);
      if (i == 7) check("wd timeout_s before", 32'(s_mc_timeout), 32'd0);
      if (i == 8) check("wd timeout_s at limit", 32'(s_mc_timeout), 32'd1);
      if (i == 10) check("wd timeout_s sticky", 32'(s_mc_timeout), 32'd1);
    end
    check("wd timeout main", 32'(mc_timeout), 32'd0);
    do_reset();
    check("wd timeout_s cleared", 32'(s_mc_timeout), 32'd0);

    // Counter saturation on the 3-bit instance.
    id_rs1 = 9; id_uses_rs1 = 1; ex_rd = 9; ex_mem_read = 1; ex_reg_write = 1;
    for (int i = 0; i < 10; i++) expect_cycle("sat stall", E_LOADUSE);
    check("sat stall main", 32'(stall_cycles), 32'd10);
    check("sat stall_s", 32'(s_stall_cycles), 32'd7);
    idle_inputs();
    ex_branch_taken = 1;
    for (int i = 0; i < 9; i++) expect_cycle("sat redirect", E_BRANCH);
    ex_branch_taken = 0;
    check("sat redirect main", 32'(redirect_cnt), 32'd9);
    check("sat redirect_s", 32'(s_redirect_cnt), 32'd7);
    check("sat stall_s held", 32'(s_stall_cycles), 32'd7);
    check("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencer for the 5-stage RISC-V pipeline. It drives every pipeline-register write-enable and flush, the PC enable, and the start pulse for the multi-cycle EX unit (mul/div). It resolves load-use stalls, taken-branch redirects, multi-cycle EX waits and data-memory wait states. Forwarding stays in the existing forwarding unit; this block only stalls and bubbles.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, width of the saturating performance counters
MC_MAX, 64, multi-cycle watchdog limit in cycles

Ports:
clk  in  1  clock
rst  in  1  reset
id_rs1, id_rs2  in  REG_AW  ID-stage source registers
id_uses_rs1, id_uses_rs2  in  1  the ID instruction really reads rs1 / rs2
ex_rd  in  REG_AW  EX-stage destination register
ex_mem_read  in  1  EX instruction is a load
ex_reg_write  in  1  EX instruction writes the register file
ex_branch_taken  in  1  branch/jump resolved taken in EX
ex_mc_op  in  1  EX holds a multi-cycle op
mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
mem_req  in  1  MEM stage accessing dmem
mem_ready  in  1  dmem completes this cycle
pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1  stage enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  load a bubble into that register
mc_start  out  1  start the multi-cycle unit
mc_timeout  out  1  sticky watchdog error
stall_cycles  out  CNT_W  cycles with pc_we=0
redirect_cnt  out  CNT_W  taken-branch redirects

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- While rst=1, on the same cycle:
  - all *_we = 0, all *_flush = 1, mc_start = 0.
  - Next edge: state=RUN, counters=0, mc_timeout=0, done_pend=0, wdog=0.
- Stage outputs are combinational from the current state and inputs. State, counters and the watchdog are registered.
- Priority (highest first): MEM_WAIT > multi-cycle > branch redirect > load-use > normal.
- MEM_WAIT: when mem_req & ~mem_ready:
  - pc/if_id/id_ex/ex_mem _we = 0.
  - mem_wb_flush = 1, with mem_wb_we = 1 so the bubble loads.
  - No other condition acts. The state is held, except for mc_done capture (below).
- FSM states: RUN, MC_BUSY, MC_DRAIN.
- RUN with ex_mc_op and no MEM_WAIT:
  - mc_start = 1 for exactly this cycle; go to MC_BUSY.
  - Same cycle: freeze pc/if_id/id_ex; ex_mem_flush = 1.
  - If MEM_WAIT is active, the start is deferred, with no pulse.
- MC_BUSY:
  - Freeze pc/if_id/id_ex; ex_mem_flush = 1; wdog increments each cycle.
  - On mc_done with no MEM_WAIT: ex_mem_we = 1, no flush, so the result advances. Go to RUN.
  - On mc_done during MEM_WAIT: set done_pend and go to MC_DRAIN.
  - wdog reaching MC_MAX sets mc_timeout, sticky until rst. The FSM keeps waiting.
- MC_DRAIN:
  - Same freeze as MC_BUSY.
  - When MEM_WAIT clears: ex_mem_we = 1 that cycle, clear done_pend, go to RUN.
- Branch redirect (RUN, ex_branch_taken):
  - if_id_flush = 1 and id_ex_flush = 1 in the same cycle; pc_we = 1, so the datapath loads the target.
  - redirect_cnt += 1.
  - Overrides load-use in the same cycle, because the ID instruction is wrong-path.
- Load-use (RUN): stall when ex_mem_read & ex_reg_write & ex_rd≠0 & ((id_uses_rs1 & rs1==ex_rd) | (id_uses_rs2 & rs2==ex_rd)).
  - pc_we = 0, if_id_we = 0, id_ex_flush = 1.
  - Lasts exactly 1 cycle, because the load moves to MEM.
  - rd = x0 never stalls.
- Normal operation: all *_we = 1, all flush = 0.
- Counters:
  - Saturate at all-ones and do not wrap.
  - stall_cycles counts every post-reset cycle with pc_we = 0.
- ex_branch_taken together with ex_mc_op is illegal; the bench asserts against it.

Decomposition:
- Package pipeline_ctrl_pkg holds the state enum (RUN, MC_BUSY, MC_DRAIN) and the REG_AW constant.
- One sub-module, sat_counter (parameter W; inputs inc, rst; output q), instanced twice.
- Load-use compare stays inline.

Test Plan:
- Load-use: lw x5 in EX, add x6,x5,x5 in ID -> one cycle of pc_we=0, if_id_we=0, id_ex_flush=1; stall_cycles=1; x6 correct afterwards.
- Load to x0: ex_rd=0, rs1=0 -> no stall; all enables 1.
- Taken branch plus a simultaneous load-use match -> if_id_flush=id_ex_flush=1, pc_we=1, no stall; redirect_cnt=1.
- Mul with mc_done 4 cycles after mc_start -> mc_start high for 1 cycle; pc frozen 4 cycles; ex_mem_flush for 4 cycles, then ex_mem_we=1 on the done cycle; state back to RUN.
- mem_ready low for 2 cycles while mc_done pulses in the first of them -> MC_DRAIN entered; ex_mem_we=1 on the cycle mem_ready=1; exactly one result; mem_wb_flush=1 for 2 cycles.
- MC_MAX=8 with no mc_done -> mc_timeout=1 after 8 cycles, stays high; cleared only by rst. CNT_W=3 run of 10 stalls -> stall_cycles=7.
